// File: rtl/operand_fetch_unit_pkg.sv
// Shared RV32I decode helpers for the operand fetch unit: opcode constants,
// instruction field positions and register-usage classification.
package operand_fetch_unit_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ofu_state_e;

  function automatic logic [6:0] opc_of(input logic [31:0] instr);
    return instr[OPC_LSB +: 7];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[RD_LSB +: 5];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[RS1_LSB +: 5];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[RS2_LSB +: 5];
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == OPC_JALR) || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_OP_IMM) || (opc == OPC_OP);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
  endfunction

  // x0 is never tracked, so an rd of zero does not count as a write.
  function automatic logic writes_rd(input logic [31:0] instr);
    logic [6:0] opc;
    opc = opc_of(instr);
    return ((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
            (opc == OPC_JALR) || (opc == OPC_LOAD) || (opc == OPC_OP_IMM) ||
            (opc == OPC_OP)) && (rd_of(instr) != 5'd0);
  endfunction

endpackage

// File: rtl/operand_fetch_unit_reg_scoreboard.sv
// Busy bit per architectural register; a set and a clear of the same
// register on one edge leaves it busy, and x0 can never be busy.
module reg_scoreboard (
  input  logic        CK_REF,
  input  logic        RST_N,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  output logic [31:0] busy
);

  logic [31:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_idx] = 1'b0;
    if (set_en) busy_next[set_idx] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// Register-file client: issues decoded instructions with captured operands
// into a one-entry execute stage, owns the write port, stalls RAW/WAW hazards.
module operand_fetch_unit
  import operand_fetch_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit BYPASS_EN   = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CK_REF,
  input  logic                   RST_N,
  input  logic                   ID_VALID,
  output logic                   ID_READY,
  input  logic [31:0]            ID_INSTR,
  output logic                   EX_VALID,
  input  logic                   EX_READY,
  output logic [31:0]            EX_INSTR,
  output logic [XLEN-1:0]        EX_RS1_DATA,
  output logic [XLEN-1:0]        EX_RS2_DATA,
  input  logic                   WB_VALID,
  input  logic [4:0]             WB_RD,
  input  logic [XLEN-1:0]        WB_DATA,
  output logic [4:0]             RF_RS1_OFFSET,
  output logic [4:0]             RF_RS2_OFFSET,
  input  logic [XLEN-1:0]        RF_RS1_DATA,
  input  logic [XLEN-1:0]        RF_RS2_DATA,
  output logic [4:0]             RF_RD_OFFSET,
  output logic [XLEN-1:0]        RF_DATA_IN,
  output logic                   RF_RD_WRN,
  output logic [31:0]            BUSY_VEC,
  output logic [STALL_CNT_W-1:0] STALL_CNT
);

  // Handshakes: a transfer happens on an edge where valid and ready are both
  // high; ID_READY never depends on ID_VALID, and EX_* stay frozen while
  // EX_VALID=1 and EX_READY=0.
  ofu_state_e      state;
  logic [4:0]      rs1, rs2, rd;
  logic [6:0]      opc;
  logic            wb_write, hit_rs1, hit_rs2, hit_rd;
  logic            raw_rs1, raw_rs2, waw, hazard, accept;
  logic [XLEN-1:0] op1, op2;

  assign opc = opc_of(ID_INSTR);
  assign rs1 = rs1_of(ID_INSTR);
  assign rs2 = rs2_of(ID_INSTR);
  assign rd  = rd_of(ID_INSTR);

  assign RF_RS1_OFFSET = rs1;
  assign RF_RS2_OFFSET = rs2;
  assign RF_RD_OFFSET  = WB_RD;
  assign RF_DATA_IN    = WB_DATA;
  assign wb_write      = WB_VALID && (WB_RD != 5'd0);
  assign RF_RD_WRN     = !wb_write;

  assign hit_rs1 = wb_write && (WB_RD == rs1);
  assign hit_rs2 = wb_write && (WB_RD == rs2);
  assign hit_rd  = wb_write && (WB_RD == rd);

  assign raw_rs1 = uses_rs1(opc) && BUSY_VEC[rs1] && !(BYPASS_EN && hit_rs1);
  assign raw_rs2 = uses_rs2(opc) && BUSY_VEC[rs2] && !(BYPASS_EN && hit_rs2);
  assign waw     = writes_rd(ID_INSTR) && BUSY_VEC[rd] && !hit_rd;
  assign hazard  = raw_rs1 || raw_rs2 || waw;

  assign ID_READY = ((state == ST_EMPTY) || EX_READY) && !hazard;
  assign accept   = ID_VALID && ID_READY;
  assign EX_VALID = (state == ST_FULL);

  // The register file writes on the same edge we capture, so its read port
  // still shows the old value; writeback data must be forwarded here.
  assign op1 = (rs1 == 5'd0) ? '0 : (hit_rs1 ? WB_DATA : RF_RS1_DATA);
  assign op2 = (rs2 == 5'd0) ? '0 : (hit_rs2 ? WB_DATA : RF_RS2_DATA);

  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_EMPTY;
      EX_INSTR    <= '0;
      EX_RS1_DATA <= '0;
      EX_RS2_DATA <= '0;
      STALL_CNT   <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL:  if (EX_READY && !accept) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
      if (accept) begin
        EX_INSTR    <= ID_INSTR;
        EX_RS1_DATA <= op1;
        EX_RS2_DATA <= op2;
      end
      if (ID_VALID && !ID_READY && (STALL_CNT != '1))
        STALL_CNT <= STALL_CNT + STALL_CNT_W'(1);
    end
  end

  reg_scoreboard u_scoreboard (
    .CK_REF  (CK_REF),
    .RST_N   (RST_N),
    .set_en  (accept && writes_rd(ID_INSTR)),
    .set_idx (rd),
    .clr_en  (WB_VALID),
    .clr_idx (WB_RD),
    .busy    (BUSY_VEC)
  );

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Randomized scoreboard bench for operand_fetch_unit with a behavioural
// register/hazard model and a decoupled output monitor.
module tb_operand_fetch_unit;

  localparam bit BYP = 1'b1;

  logic        CK_REF = 1'b0;
  logic        RST_N;
  logic        ID_VALID, ID_READY, EX_VALID, EX_READY;
  logic [31:0] ID_INSTR, EX_INSTR, EX_RS1_DATA, EX_RS2_DATA;
  logic        WB_VALID;
  logic [4:0]  WB_RD;
  logic [31:0] WB_DATA;
  logic [4:0]  RF_RS1_OFFSET, RF_RS2_OFFSET, RF_RD_OFFSET;
  logic [31:0] RF_RS1_DATA, RF_RS2_DATA, RF_DATA_IN;
  logic        RF_RD_WRN;
  logic [31:0] BUSY_VEC;
  logic [15:0] STALL_CNT;

  operand_fetch_unit #(.XLEN(32), .BYPASS_EN(BYP), .STALL_CNT_W(16)) dut (
    .CK_REF(CK_REF), .RST_N(RST_N),
    .ID_VALID(ID_VALID), .ID_READY(ID_READY), .ID_INSTR(ID_INSTR),
    .EX_VALID(EX_VALID), .EX_READY(EX_READY), .EX_INSTR(EX_INSTR),
    .EX_RS1_DATA(EX_RS1_DATA), .EX_RS2_DATA(EX_RS2_DATA),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .RF_RS1_OFFSET(RF_RS1_OFFSET), .RF_RS2_OFFSET(RF_RS2_OFFSET),
    .RF_RS1_DATA(RF_RS1_DATA), .RF_RS2_DATA(RF_RS2_DATA),
    .RF_RD_OFFSET(RF_RD_OFFSET), .RF_DATA_IN(RF_DATA_IN), .RF_RD_WRN(RF_RD_WRN),
    .BUSY_VEC(BUSY_VEC), .STALL_CNT(STALL_CNT)
  );

  // clock / register file environment
  always #5 CK_REF = ~CK_REF;

  logic [31:0] rf [32];
  always @(posedge CK_REF) if (RF_RD_WRN == 1'b0) rf[RF_RD_OFFSET] <= RF_DATA_IN;
  assign RF_RS1_DATA = (RF_RS1_OFFSET == 5'd0) ? 32'd0 : rf[RF_RS1_OFFSET];
  assign RF_RS2_DATA = (RF_RS2_OFFSET == 5'd0) ? 32'd0 : rf[RF_RS2_OFFSET];

  // reference model state
  logic [95:0] exp_q[$];
  logic [4:0]  pending[$];
  logic [31:0] arch [32];
  logic [31:0] busy_m;
  logic [15:0] stall_m;
  logic        mon_en;
  int          n_checks, n_pass, n_acc;
  logic [95:0] mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic m_rs1(input logic [6:0] op);
    case (op)
      7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_rs2(input logic [6:0] op);
    case (op)
      7'h63, 7'h23, 7'h33: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_wr(input logic [6:0] op);
    case (op)
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic hit(input logic [4:0] r);
    return WB_VALID && (WB_RD == r) && (r != 5'd0);
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom();
    w[6:0]   = ops[$urandom_range(0, 10)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // monitor: compares the output stage against the oldest expected entry
  always @(negedge CK_REF) begin
    if (mon_en) begin
      check("ex_valid", 32'(EX_VALID), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        mon_e = exp_q[0];
        check("ex_instr", EX_INSTR, mon_e[95:64]);
        check("ex_rs1_data", EX_RS1_DATA, mon_e[63:32]);
        check("ex_rs2_data", EX_RS2_DATA, mon_e[31:0]);
        if (EX_READY) void'(exp_q.pop_front());
      end
    end
  end

  // driver: applies one cycle of inputs and advances the reference model
  task automatic do_cycle(input logic idv, input logic [31:0] ins, input logic exr,
                          input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                          output logic acc);
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic        haz, rdy;
    logic [31:0] o1, o2;
    @(posedge CK_REF); #1;
    ID_VALID = idv; ID_INSTR = ins; EX_READY = exr;
    WB_VALID = wbv; WB_RD = wbrd; WB_DATA = wbd;
    #5;
    op = ins[6:0]; rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
    haz = (m_rs1(op) && busy_m[rs1] && !(BYP && hit(rs1))) ||
          (m_rs2(op) && busy_m[rs2] && !(BYP && hit(rs2))) ||
          (m_wr(op) && rd != 5'd0 && busy_m[rd] && !hit(rd));
    rdy = (exp_q.size() == 0) && !haz;
    check("id_ready", 32'(ID_READY), 32'(rdy));
    check("rf_rd_wrn", 32'(RF_RD_WRN), 32'(!(wbv && wbrd != 5'd0)));
    check("rf_rd_offset", 32'(RF_RD_OFFSET), 32'(wbrd));
    check("rf_data_in", RF_DATA_IN, wbd);
    check("rf_rs1_offset", 32'(RF_RS1_OFFSET), 32'(rs1));
    check("rf_rs2_offset", 32'(RF_RS2_OFFSET), 32'(rs2));
    check("busy_vec", BUSY_VEC, busy_m);
    check("stall_cnt", 32'(STALL_CNT), 32'(stall_m));
    acc = idv && rdy;
    if (acc) begin
      o1 = (rs1 == 5'd0) ? 32'd0 : (hit(rs1) ? wbd : arch[rs1]);
      o2 = (rs2 == 5'd0) ? 32'd0 : (hit(rs2) ? wbd : arch[rs2]);
      exp_q.push_back({ins, o1, o2});
      n_acc++;
      if (m_wr(op) && rd != 5'd0) pending.push_back(rd);
    end
    if (wbv) busy_m[wbrd] = 1'b0;
    if (acc && m_wr(op) && rd != 5'd0) busy_m[rd] = 1'b1;
    busy_m[0] = 1'b0;
    if (wbv && wbrd != 5'd0) arch[wbrd] = wbd;
    if (idv && !rdy && stall_m != 16'hFFFF) stall_m++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    pending.delete();
    busy_m  = '0;
    stall_m = '0;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 64 && pending.size() != 0; i++)
      do_cycle(1'b0, 32'd0, 1'b1, 1'b1, pending.pop_front(), $urandom(), a);
    do_cycle(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, a);
    check("drained", busy_m | BUSY_VEC, 32'd0);
  endtask

  initial begin
    logic        a, idv, exr, wbv;
    logic [4:0]  wbrd;
    logic [31:0] cur;
    int          r, k;
    for (int i = 0; i < 32; i++) begin rf[i] = '0; arch[i] = '0; end
    n_checks = 0; n_pass = 0; n_acc = 0; mon_en = 1'b0;
    model_reset();
    ID_VALID = 0; ID_INSTR = 0; EX_READY = 0; WB_VALID = 0; WB_RD = 0; WB_DATA = 0;
    RST_N = 1'b0;
    #1;
    check("rst_ex_valid", 32'(EX_VALID), 32'd0);
    check("rst_ex_instr", EX_INSTR, 32'd0);
    check("rst_ex_rs1", EX_RS1_DATA, 32'd0);
    check("rst_ex_rs2", EX_RS2_DATA, 32'd0);
    check("rst_busy", BUSY_VEC, 32'd0);
    check("rst_stall", 32'(STALL_CNT), 32'd0);
    repeat (2) @(posedge CK_REF);
    #1 RST_N = 1'b1; mon_en = 1'b1;

    // reset while holding an instruction with x3 busy
    do_cycle(1'b1, enc(7'h13, 5'd3, 5'd0, 5'd1), 1'b0, 1'b0, 5'd0, 32'd0, a);
    do_cycle(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, a);
    @(posedge CK_REF); #2;
    mon_en = 1'b0;
    RST_N = 1'b0;
    #1;
    check("midrst_ex_valid", 32'(EX_VALID), 32'd0);
    check("midrst_busy", BUSY_VEC, 32'd0);
    check("midrst_rf_rd_wrn", 32'(RF_RD_WRN), 32'd1);
    model_reset();
    @(posedge CK_REF);
    #1 RST_N = 1'b1; mon_en = 1'b1;

    // back-to-back independent issue
    do_cycle(1'b1, enc(7'h13, 5'd1, 5'd0, 5'd5), 1'b1, 1'b0, 5'd0, 32'd0, a);
    do_cycle(1'b1, enc(7'h13, 5'd2, 5'd0, 5'd7), 1'b1, 1'b0, 5'd0, 32'd0, a);
    do_cycle(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, a);
    drain();

    // RAW on x3 resolved by same-cycle writeback bypass
    do_cycle(1'b1, enc(7'h13, 5'd3, 5'd0, 5'd1), 1'b1, 1'b0, 5'd0, 32'd0, a);
    repeat (3) do_cycle(1'b1, enc(7'h33, 5'd4, 5'd3, 5'd3), 1'b1, 1'b0, 5'd0, 32'd0, a);
    do_cycle(1'b1, enc(7'h33, 5'd4, 5'd3, 5'd3), 1'b1, 1'b1, 5'd3, 32'h2A, a);
    check("raw_bypass_accept", 32'(a), 32'd1);
    pending.delete(); pending.push_back(5'd4);
    drain();

    // x0 write suppression and zero operands
    do_cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 32'hDEAD, a);
    do_cycle(1'b1, enc(7'h13, 5'd0, 5'd0, 5'd1), 1'b1, 1'b0, 5'd0, 32'd0, a);
    do_cycle(1'b1, enc(7'h33, 5'd5, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 32'd0, a);
    drain();

    // backpressure while full
    do_cycle(1'b1, enc(7'h13, 5'd6, 5'd0, 5'd2), 1'b1, 1'b0, 5'd0, 32'd0, a);
    repeat (3) do_cycle(1'b1, enc(7'h13, 5'd7, 5'd0, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0, a);
    do_cycle(1'b1, enc(7'h13, 5'd7, 5'd0, 5'd3), 1'b1, 1'b0, 5'd0, 32'd0, a);
    drain();

    // WAW on x5 with writeback and re-issue on the same edge
    do_cycle(1'b1, enc(7'h13, 5'd5, 5'd0, 5'd9), 1'b1, 1'b0, 5'd0, 32'd0, a);
    do_cycle(1'b1, enc(7'h13, 5'd5, 5'd0, 5'd9), 1'b1, 1'b1, 5'd5, 32'h55, a);
    check("waw_same_edge_accept", 32'(a), 32'd1);
    do_cycle(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, a);
    pending.delete(); pending.push_back(5'd5);
    drain();

    // randomized traffic
    cur = rand_instr();
    for (int c = 0; c < 2500; c++) begin
      idv = ($urandom_range(0, 3) != 0);
      exr = ($urandom_range(0, 3) != 0);
      wbv = 1'b0; wbrd = 5'd0;
      r = $urandom_range(0, 9);
      if (r < 4 && pending.size() != 0) begin
        k = $urandom_range(0, pending.size() - 1);
        wbv = 1'b1; wbrd = pending[k]; pending.delete(k);
      end else if (r == 9) begin
        wbv = 1'b1; wbrd = 5'($urandom_range(0, 7));
      end
      do_cycle(idv, cur, exr, wbv, wbrd, $urandom(), a);
      if (a) cur = rand_instr();
    end
    drain();
    check("issued_enough", 32'(n_acc > 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
Client-side controller for the register file. It accepts decoded-stage instructions and drives the register file's RS1/RS2 read offsets. It captures operands, with writeback bypass, into a one-entry output stage for execute. It also owns the register file's write port, driving RD offset, data and read/write-not from the writeback bus. A 32-entry scoreboard tracks in-flight destination registers and stalls RAW and WAW hazards.

Parameters:
XLEN, 32, datapath width of operands and writeback data
BYPASS_EN, 1, 1 = forward same-cycle writeback data into captured operands; 0 = stall until the register file holds the value
STALL_CNT_W, 16, width of the saturating stall counter

Ports:
CK_REF  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
ID_VALID  in  1  instruction offered
ID_READY  out  1  instruction accepted this cycle when ID_VALID=1
ID_INSTR  in  32  RV32I instruction word
EX_VALID  out  1  output stage holds an issued instruction
EX_READY  in  1  execute consumes the output stage
EX_INSTR  out  32  issued instruction
EX_RS1_DATA  out  XLEN  captured rs1 operand
EX_RS2_DATA  out  XLEN  captured rs2 operand
WB_VALID  in  1  writeback result valid
WB_RD  in  5  writeback destination
WB_DATA  in  XLEN  writeback value
RF_RS1_OFFSET  out  5  register file rs1 read address (ID_INSTR[19:15])
RF_RS2_OFFSET  out  5  register file rs2 read address (ID_INSTR[24:20])
RF_RS1_DATA  in  XLEN  register file rs1 read data (combinational)
RF_RS2_DATA  in  XLEN  register file rs2 read data (combinational)
RF_RD_OFFSET  out  5  register file write address (= WB_RD)
RF_DATA_IN  out  XLEN  register file write data (= WB_DATA)
RF_RD_WRN  out  1  0 = write this edge, 1 = read only
BUSY_VEC  out  32  scoreboard state; bit 0 is always 0
STALL_CNT  out  STALL_CNT_W  cycles with ID_VALID=1 and ID_READY=0, saturating

Behaviour:
- Reset (async, RST_N low) values: EX_VALID=0, EX_INSTR/EX_RS1_DATA/EX_RS2_DATA=0, BUSY_VEC=0, STALL_CNT=0, state=EMPTY. RF_RD_WRN is combinational from WB inputs. Reset mid-operation discards the held instruction and all busy bits.
- Write port (combinational): RF_RD_WRN = !(WB_VALID && WB_RD!=0). WB_RD=0 never writes.
- Opcode classes (ID_INSTR[6:0]):
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - uses_rs2: BRANCH, STORE, OP.
  - writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd!=0.
  - Any other opcode uses nothing and passes through.
- wb_hit(r) = WB_VALID && WB_RD==r && r!=0.
- Hazards:
  - RAW: uses_rsN && busy[rsN] && !(BYPASS_EN && wb_hit(rsN)).
  - WAW: writes_rd && busy[rd] && !wb_hit(rd).
  - With BYPASS_EN=0, any busy rsN stalls regardless of wb_hit.
- FSM states EMPTY and FULL:
  - ID_READY = (EMPTY || EX_READY) && !hazard.
  - Accept (ID_VALID&&ID_READY): state→FULL, capture instruction and operands on that edge; EX_VALID rises 1 cycle after accept.
  - FULL && EX_READY && !accept: →EMPTY.
  - FULL && EX_READY && accept: remain FULL and reload (full throughput, 1 instruction/cycle).
  - FULL && !EX_READY: all EX_* held stable.
- Operand capture: EX_RSn_DATA = wb_hit(rsN) ? WB_DATA : RF_RSn_DATA. The bypass is mandatory because the register file updates on the same edge. rsN=0 yields 0.
- Scoreboard per edge:
  - Writeback clears busy[WB_RD] when WB_VALID.
  - An accepted writes_rd instruction sets busy[rd].
  - When both target the same register, set wins.
  - WB to a non-busy register still writes the register file; the scoreboard is unchanged.
- STALL_CNT increments on ID_VALID && !ID_READY and saturates at all-ones.

Decomposition:
- Shared package: RV32I opcode constants (OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), field bit-position constants, and functions uses_rs1/uses_rs2/writes_rd.
- Sub-module reg_scoreboard: 32-bit busy vector with set/clear ports, set-wins priority and bit 0 tied low. Hazard and FSM logic stay in the top module.

Test Plan:
- Reset mid-FULL: assert RST_N=0 while EX_VALID=1, BUSY_VEC=0x8 → EX_VALID=0 and BUSY_VEC=0 immediately (asynchronous); RF_RD_WRN=1 with WB_VALID=0.
- Back-to-back independent instructions, EX_READY=1: addi x1,x0,5 then addi x2,x0,7 → EX_VALID on consecutive cycles, ID_READY stays 1, BUSY_VEC=0x6.
- RAW with bypass: addi x3 issued, then add x4,x3,x3 → ID_READY=0 and STALL_CNT counts up until the cycle with WB_VALID=1, WB_RD=3, WB_DATA=0x2A. The instruction is accepted that cycle with EX_RS1_DATA=EX_RS2_DATA=0x2A, and RF_RD_WRN=0 that cycle.
- x0 handling: WB_VALID=1, WB_RD=0 → RF_RD_WRN=1. addi x0,x0,1 accepted → BUSY_VEC unchanged; add x5,x0,x0 → operands 0.
- Backpressure: EX_READY=0 for 3 cycles while FULL and ID_VALID=1 → EX_INSTR/EX_RS*_DATA stable, ID_READY=0, STALL_CNT +3.
- Simultaneous set/clear: WB_RD=5 in the same cycle as accepting addi x5,x0,9 while busy[5]=1 → accepted (WAW resolved), BUSY_VEC bit 5 remains 1.
